// File: rtl/apb_bridge_pkg.sv
// Shared types and address map for the AHB-to-APB bridge.
// Holds the bridge FSM states and the peripheral select decode.
package apb_bridge_pkg;

    localparam int SEL_W = 3;

    localparam logic [31:0] REGION_SIZE  = 32'h0400_0000;
    localparam logic [31:0] REGION0_BASE = 32'h8000_0000;
    localparam logic [31:0] REGION1_BASE = 32'h8400_0000;
    localparam logic [31:0] REGION2_BASE = 32'h8800_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WWAIT,
        ST_READ,
        ST_WRITE,
        ST_WRITEP,
        ST_RENABLE,
        ST_WENABLE,
        ST_WENABLEP
    } state_t;

    function automatic logic [SEL_W-1:0] sel_decode(input logic [31:0] addr);
        logic [SEL_W-1:0] s;
        s = '0;
        if (addr >= REGION0_BASE && addr < REGION0_BASE + REGION_SIZE)
            s = 3'b001;
        else if (addr >= REGION1_BASE && addr < REGION1_BASE + REGION_SIZE)
            s = 3'b010;
        else if (addr >= REGION2_BASE && addr < REGION2_BASE + REGION_SIZE)
            s = 3'b100;
        return s;
    endfunction

endpackage

// File: rtl/apb_controller.sv
// APB master FSM downstream of the AHB slave interface.
// Runs SETUP/ACCESS per transfer and stalls AHB via hreadyout.
module apb_controller
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NSEL   = 3
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              valid,
    input  logic              hwrite,
    input  logic              hwritereg,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [ADDR_W-1:0] haddr1,
    input  logic [ADDR_W-1:0] haddr2,
    input  logic [DATA_W-1:0] hwdata,
    input  logic [DATA_W-1:0] prdata,
    output logic [NSEL-1:0]   pselx,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic              hreadyout,
    output logic [DATA_W-1:0] hrdata,
    output logic [1:0]        hresp
);

    state_t            state_q, state_d;
    logic [NSEL-1:0]   pselx_q, pselx_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              hready_q, hready_d;

    function automatic logic [NSEL-1:0] sel(input logic [ADDR_W-1:0] a);
        return NSEL'(sel_decode(32'(a)));
    endfunction

    // State and output registers
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q   <= ST_IDLE;
            pselx_q   <= '0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            hready_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            pselx_q   <= pselx_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            hready_q  <= hready_d;
        end
    end

    // Next-state selection
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_RENABLE, ST_WENABLE: begin
                if (valid && !hwrite)
                    state_d = ST_READ;
                else if (valid && hwrite)
                    state_d = ST_WWAIT;
                else
                    state_d = ST_IDLE;
            end
            ST_WWAIT:    state_d = valid ? ST_WRITEP : ST_WRITE;
            ST_READ:     state_d = ST_RENABLE;
            ST_WRITE:    state_d = valid ? ST_WENABLEP : ST_WENABLE;
            ST_WRITEP:   state_d = ST_WENABLEP;
            ST_WENABLEP: begin
                if (!hwritereg)
                    state_d = ST_READ;
                else
                    state_d = valid ? ST_WRITEP : ST_WRITE;
            end
            default:     state_d = ST_IDLE;
        endcase
    end

    // Registered APB/AHB outputs for the next cycle; unlisted ones hold
    always_comb begin
        pselx_d   = pselx_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        hready_d  = hready_q;
        unique case (state_q)
            ST_IDLE, ST_RENABLE, ST_WENABLE: begin
                penable_d = 1'b0;
                if (valid && !hwrite) begin
                    paddr_d  = haddr;
                    pwrite_d = 1'b0;
                    pselx_d  = sel(haddr);
                    hready_d = 1'b0;
                end else begin
                    pselx_d  = '0;
                    hready_d = 1'b1;
                end
            end
            ST_WWAIT: begin
                paddr_d   = haddr1;
                pwdata_d  = hwdata;
                pwrite_d  = 1'b1;
                pselx_d   = sel(haddr1);
                penable_d = 1'b0;
                hready_d  = 1'b0;
            end
            ST_READ, ST_WRITE, ST_WRITEP: begin
                penable_d = 1'b1;
                hready_d  = 1'b1;
            end
            ST_WENABLEP: begin
                paddr_d   = haddr2;
                pselx_d   = sel(haddr2);
                penable_d = 1'b0;
                hready_d  = 1'b0;
                if (hwritereg) begin
                    pwdata_d = hwdata;
                    pwrite_d = 1'b1;
                end else begin
                    pwrite_d = 1'b0;
                end
            end
            default: begin
                pselx_d   = '0;
                penable_d = 1'b0;
                hready_d  = 1'b1;
            end
        endcase
    end

    assign pselx     = pselx_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign hreadyout = hready_q;
    assign hrdata    = prdata;
    assign hresp     = 2'b00;

endmodule

// File: tb/tb_apb_controller.sv
// Directed bench for apb_controller.
// Models the upstream address/write delay registers in stimulus.
module tb_apb_controller;

    logic        hclk;
    logic        hresetn;
    logic        valid;
    logic        hwrite;
    logic        hwritereg;
    logic [31:0] haddr;
    logic [31:0] haddr1;
    logic [31:0] haddr2;
    logic [31:0] hwdata;
    logic [31:0] prdata;
    logic [2:0]  pselx;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        hreadyout;
    logic [31:0] hrdata;
    logic [1:0]  hresp;

    int n_tests;
    int n_fail;

    apb_controller dut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .valid     (valid),
        .hwrite    (hwrite),
        .hwritereg (hwritereg),
        .haddr     (haddr),
        .haddr1    (haddr1),
        .haddr2    (haddr2),
        .hwdata    (hwdata),
        .prdata    (prdata),
        .pselx     (pselx),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .hreadyout (hreadyout),
        .hrdata    (hrdata),
        .hresp     (hresp)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One bus cycle: shift the delay pipes, drive new inputs, then
    // sample 1 ns after the rising edge.
    task automatic cyc(input logic v, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
        @(negedge hclk);
        haddr2    = haddr1;
        haddr1    = haddr;
        hwritereg = hwrite;
        valid     = v;
        hwrite    = w;
        haddr     = a;
        hwdata    = d;
        @(posedge hclk);
        #1;
    endtask

    task automatic idle_state(input string tag);
        check({tag, "_psel"}, 32'(pselx), 32'h0);
        check({tag, "_pen"}, 32'(penable), 32'h0);
        check({tag, "_rdy"}, 32'(hreadyout), 32'h1);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        hresetn   = 1'b0;
        valid     = 1'b0;
        hwrite    = 1'b0;
        hwritereg = 1'b0;
        haddr     = '0;
        haddr1    = '0;
        haddr2    = '0;
        hwdata    = '0;
        prdata    = 32'hDEAD_BEEF;
        #12;
        check("rst_psel", 32'(pselx), 32'h0);
        check("rst_pen", 32'(penable), 32'h0);
        check("rst_pwrite", 32'(pwrite), 32'h0);
        check("rst_paddr", paddr, 32'h0);
        check("rst_pwdata", pwdata, 32'h0);
        check("rst_rdy", 32'(hreadyout), 32'h1);
        check("rst_hresp", 32'(hresp), 32'h0);
        @(negedge hclk);
        hresetn = 1'b1;

        // single read
        cyc(1'b1, 1'b0, 32'h8000_0010, 32'h0);
        check("rd_setup_psel", 32'(pselx), 32'h1);
        check("rd_setup_pen", 32'(penable), 32'h0);
        check("rd_setup_pwr", 32'(pwrite), 32'h0);
        check("rd_setup_paddr", paddr, 32'h8000_0010);
        check("rd_setup_rdy", 32'(hreadyout), 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 32'h0);
        check("rd_acc_pen", 32'(penable), 32'h1);
        check("rd_acc_psel", 32'(pselx), 32'h1);
        check("rd_acc_rdy", 32'(hreadyout), 32'h1);
        check("rd_acc_hrdata", hrdata, 32'hDEAD_BEEF);
        cyc(1'b0, 1'b0, 32'h0, 32'h0);
        idle_state("rd_end");

        // single write
        cyc(1'b1, 1'b1, 32'h8400_0004, 32'h0);
        check("wr_wait_psel", 32'(pselx), 32'h0);
        check("wr_wait_rdy", 32'(hreadyout), 32'h1);
        cyc(1'b0, 1'b0, 32'h0, 32'h1234_5678);
        check("wr_setup_psel", 32'(pselx), 32'h2);
        check("wr_setup_pwr", 32'(pwrite), 32'h1);
        check("wr_setup_paddr", paddr, 32'h8400_0004);
        check("wr_setup_pwdata", pwdata, 32'h1234_5678);
        check("wr_setup_pen", 32'(penable), 32'h0);
        check("wr_setup_rdy", 32'(hreadyout), 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 32'h0);
        check("wr_acc_pen", 32'(penable), 32'h1);
        check("wr_acc_rdy", 32'(hreadyout), 32'h1);
        cyc(1'b0, 1'b0, 32'h0, 32'h0);
        idle_state("wr_end");

        // back-to-back writes
        cyc(1'b1, 1'b1, 32'h8800_0000, 32'h0);
        cyc(1'b1, 1'b1, 32'h8800_0004, 32'hAAAA_0001);
        check("bb_s1_paddr", paddr, 32'h8800_0000);
        check("bb_s1_pwdata", pwdata, 32'hAAAA_0001);
        check("bb_s1_psel", 32'(pselx), 32'h4);
        check("bb_s1_pen", 32'(penable), 32'h0);
        check("bb_s1_rdy", 32'(hreadyout), 32'h0);
        cyc(1'b0, 1'b1, 32'h8800_0004, 32'h0);
        check("bb_a1_pen", 32'(penable), 32'h1);
        check("bb_a1_paddr", paddr, 32'h8800_0000);
        cyc(1'b0, 1'b0, 32'h0, 32'hBBBB_0002);
        check("bb_s2_paddr", paddr, 32'h8800_0004);
        check("bb_s2_pwdata", pwdata, 32'hBBBB_0002);
        check("bb_s2_pwr", 32'(pwrite), 32'h1);
        check("bb_s2_pen", 32'(penable), 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 32'h0);
        check("bb_a2_pen", 32'(penable), 32'h1);
        check("bb_a2_paddr", paddr, 32'h8800_0004);
        cyc(1'b0, 1'b0, 32'h0, 32'h0);
        idle_state("bb_end");

        // write then read
        prdata = 32'hCAFE_F00D;
        cyc(1'b1, 1'b1, 32'h8400_0008, 32'h0);
        cyc(1'b1, 1'b0, 32'h8000_0020, 32'h5555_AAAA);
        check("wr_rd_s1_paddr", paddr, 32'h8400_0008);
        check("wr_rd_s1_psel", 32'(pselx), 32'h2);
        cyc(1'b0, 1'b0, 32'h8000_0020, 32'h0);
        check("wr_rd_a1_pen", 32'(penable), 32'h1);
        cyc(1'b0, 1'b0, 32'h0, 32'h0);
        check("wr_rd_s2_paddr", paddr, 32'h8000_0020);
        check("wr_rd_s2_pwr", 32'(pwrite), 32'h0);
        check("wr_rd_s2_psel", 32'(pselx), 32'h1);
        check("wr_rd_s2_pen", 32'(penable), 32'h0);
        check("wr_rd_s2_rdy", 32'(hreadyout), 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 32'h0);
        check("wr_rd_a2_pen", 32'(penable), 32'h1);
        check("wr_rd_a2_hrdata", hrdata, 32'hCAFE_F00D);
        cyc(1'b0, 1'b0, 32'h0, 32'h0);
        idle_state("wr_rd_end");

        // unmapped read
        cyc(1'b1, 1'b0, 32'h9000_0000, 32'h0);
        check("um_s_psel", 32'(pselx), 32'h0);
        check("um_s_paddr", paddr, 32'h9000_0000);
        check("um_s_rdy", 32'(hreadyout), 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 32'h0);
        check("um_a_psel", 32'(pselx), 32'h0);
        check("um_a_pen", 32'(penable), 32'h1);
        check("um_a_rdy", 32'(hreadyout), 32'h1);
        cyc(1'b0, 1'b0, 32'h0, 32'h0);
        idle_state("um_end");

        // asynchronous reset in the middle of ACCESS
        cyc(1'b1, 1'b0, 32'h8000_0040, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 32'h0);
        check("ar_pre_pen", 32'(penable), 32'h1);
        #2;
        hresetn = 1'b0;
        #1;
        check("ar_psel", 32'(pselx), 32'h0);
        check("ar_pen", 32'(penable), 32'h0);
        check("ar_paddr", paddr, 32'h0);
        check("ar_pwr", 32'(pwrite), 32'h0);
        check("ar_rdy", 32'(hreadyout), 32'h1);
        @(negedge hclk);
        hresetn = 1'b1;
        cyc(1'b0, 1'b0, 32'h0, 32'h0);
        idle_state("ar_idle");
        cyc(1'b1, 1'b0, 32'h8400_0010, 32'h0);
        check("ar_next_psel", 32'(pselx), 32'h2);
        check("ar_next_pen", 32'(penable), 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 32'h0);
        check("ar_next_acc", 32'(penable), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
